simd_sat_addsub: RTL and testbench

//  Parametrised, pipelined packed-SIMD signed add/subtract unit with per-lane

---
 rtl/simd_sat_addsub_if.sv | 28 ++
 rtl/simd_sat_addsub.sv | 103 ++++++++++
 tb/tb_simd_sat_addsub.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/simd_sat_addsub_if.sv
// Operand/result handshake bundle for the packed-SIMD saturating add/sub unit.
// master = producer/consumer side, slave = the arithmetic unit.
interface simd_sat_addsub_if #(
  parameter int LANE_W = 4,
  parameter int LANES  = 4
);
  localparam int DATA_W = LANE_W * LANES;

  logic              in_valid;
  logic              in_ready;
  logic [1:0]        op;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [LANES-1:0]  out_ovf;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/simd_sat_addsub.sv
// Packed-SIMD signed add/sub, per-lane saturate or wrap; 2-cycle latency, 1 op/cycle.
// Backpressure: result held while out_ready=0; in_ready drops once both stages are full.
module simd_sat_addsub #(
  parameter int LANE_W = 4,
  parameter int LANES  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  simd_sat_addsub_if.slave     bus,
  input  logic                 sticky_clr,
  output logic [LANES-1:0]     sticky_ovf
);
  localparam int DATA_W = LANE_W * LANES;

  logic              s1_valid;
  logic [DATA_W-1:0] s1_a;
  logic [DATA_W-1:0] s1_b;
  logic [1:0]        s1_op;

  logic              s2_valid;
  logic [DATA_W-1:0] s2_data;
  logic [LANES-1:0]  s2_ovf;

  logic              s2_adv;
  logic              in_ready;
  logic [DATA_W-1:0] calc_data;
  logic [LANES-1:0]  calc_ovf;

  assign s2_adv   = s1_valid & (~s2_valid | bus.out_ready);
  assign in_ready = ~rst & (~s1_valid | s2_adv);

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_valid;
  assign bus.out_data  = s2_data;
  assign bus.out_ovf   = s2_ovf;

  // Each lane is sign-extended by one bit so the true result always fits;
  // overflow is then simply the top two bits disagreeing.
  for (genvar lane = 0; lane < LANES; lane++) begin : g_lane
    logic [LANE_W-1:0] la;
    logic [LANE_W-1:0] lb;
    logic [LANE_W:0]   ax;
    logic [LANE_W:0]   bx;
    logic [LANE_W:0]   r;
    logic              ovf;
    logic [LANE_W-1:0] sat_val;

    assign la  = s1_a[lane*LANE_W +: LANE_W];
    assign lb  = s1_b[lane*LANE_W +: LANE_W];
    assign ax  = {la[LANE_W-1], la};
    assign bx  = {lb[LANE_W-1], lb};
    assign r   = s1_op[0] ? (ax - bx) : (ax + bx);
    assign ovf = r[LANE_W] ^ r[LANE_W-1];

    // Negative overflow clamps to min (1000..), positive to max (0111..).
    assign sat_val = r[LANE_W] ? {1'b1, {(LANE_W-1){1'b0}}}
                               : {1'b0, {(LANE_W-1){1'b1}}};

    assign calc_data[lane*LANE_W +: LANE_W] = (ovf && !s1_op[1]) ? sat_val : r[LANE_W-1:0];
    assign calc_ovf[lane] = ovf;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
    end else if (in_ready) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_a  <= bus.a;
        s1_b  <= bus.b;
        s1_op <= bus.op;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_ovf   <= '0;
    end else if (s2_adv) begin
      s2_valid <= 1'b1;
      s2_data  <= calc_data;
      s2_ovf   <= calc_ovf;
    end else if (bus.out_ready) begin
      s2_valid <= 1'b0;
    end
  end

  // A clear coinciding with a load keeps only the newly loaded flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_ovf <= '0;
    end else if (sticky_clr) begin
      sticky_ovf <= s2_adv ? calc_ovf : '0;
    end else if (s2_adv) begin
      sticky_ovf <= sticky_ovf | calc_ovf;
    end
  end
endmodule

// File: tb/tb_simd_sat_addsub.sv
// Directed-vector bench for simd_sat_addsub (LANE_W=4, LANES=4).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_simd_sat_addsub;
  logic       clk;
  logic       rst;
  logic       sticky_clr;
  logic [3:0] sticky_ovf;
  int         tests_run;
  int         tests_failed;

  simd_sat_addsub_if #(.LANE_W(4), .LANES(4)) bus ();

  simd_sat_addsub #(.LANE_W(4), .LANES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .sticky_clr (sticky_clr),
    .sticky_ovf (sticky_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one op for exactly one cycle; callers only use this with in_ready=1.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.op       = op;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; sticky_clr = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.a = '0; bus.b = '0; bus.op = '0;
    tick(); tick();
    tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset out_valid: got %b need 0", bus.out_valid); end
    tests_run++; if (bus.out_data !== 16'h0000) begin tests_failed++; $display("FAIL reset out_data: got %h need 0000", bus.out_data); end
    tests_run++; if (bus.out_ovf !== 4'h0) begin tests_failed++; $display("FAIL reset out_ovf: got %h need 0", bus.out_ovf); end
    tests_run++; if (sticky_ovf !== 4'h0) begin tests_failed++; $display("FAIL reset sticky: got %h need 0", sticky_ovf); end
    tests_run++; if (bus.in_ready !== 1'b0) begin tests_failed++; $display("FAIL reset in_ready: got %b need 0", bus.in_ready); end
    rst = 1'b0;
    #1;
    tests_run++; if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL post_reset in_ready: got %b need 1", bus.in_ready); end
  endtask

  task automatic test_sat_add();
    issue(16'h7777, 16'h1111, 2'b00);
    tick();
    tests_run++; if (bus.out_data !== 16'h7777) begin tests_failed++; $display("FAIL sat_add_pos data: got %h need 7777", bus.out_data); end
    tests_run++; if (bus.out_ovf !== 4'hF) begin tests_failed++; $display("FAIL sat_add_pos ovf: got %h need F", bus.out_ovf); end
    tests_run++; if (sticky_ovf !== 4'hF) begin tests_failed++; $display("FAIL sat_add_pos sticky: got %h need F", sticky_ovf); end
    tick();
    issue(16'h8888, 16'hFFFF, 2'b00);
    tick();
    tests_run++; if (bus.out_data !== 16'h8888) begin tests_failed++; $display("FAIL sat_add_neg data: got %h need 8888", bus.out_data); end
    tests_run++; if (bus.out_ovf !== 4'hF) begin tests_failed++; $display("FAIL sat_add_neg ovf: got %h need F", bus.out_ovf); end
    tick();
  endtask

  task automatic test_mixed_lanes();
    issue(16'h3A51, 16'h2C72, 2'b00);
    tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL mixed early_valid: got %b need 0", bus.out_valid); end
    tick();
    tests_run++; if (bus.out_valid !== 1'b1) begin tests_failed++; $display("FAIL mixed latency_valid: got %b need 1", bus.out_valid); end
    tests_run++; if (bus.out_data !== 16'h5873) begin tests_failed++; $display("FAIL mixed data: got %h need 5873", bus.out_data); end
    tests_run++; if (bus.out_ovf !== 4'h6) begin tests_failed++; $display("FAIL mixed ovf: got %h need 6", bus.out_ovf); end
    tick();
    tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL mixed drain_valid: got %b need 0", bus.out_valid); end
  endtask

  task automatic test_sub_wrap();
    issue(16'h8000, 16'h1000, 2'b01);
    tick();
    tests_run++; if (bus.out_data !== 16'h8000) begin tests_failed++; $display("FAIL sub_min data: got %h need 8000", bus.out_data); end
    tests_run++; if (bus.out_ovf !== 4'h8) begin tests_failed++; $display("FAIL sub_min ovf: got %h need 8", bus.out_ovf); end
    tick();
    issue(16'h0000, 16'h8888, 2'b01);
    tick();
    tests_run++; if (bus.out_data !== 16'h7777) begin tests_failed++; $display("FAIL sub_negmin data: got %h need 7777", bus.out_data); end
    tests_run++; if (bus.out_ovf !== 4'hF) begin tests_failed++; $display("FAIL sub_negmin ovf: got %h need F", bus.out_ovf); end
    tick();
    issue(16'h7777, 16'h1111, 2'b10);
    tick();
    tests_run++; if (bus.out_data !== 16'h8888) begin tests_failed++; $display("FAIL wrap_add data: got %h need 8888", bus.out_data); end
    tests_run++; if (bus.out_ovf !== 4'hF) begin tests_failed++; $display("FAIL wrap_add ovf: got %h need F", bus.out_ovf); end
    tick();
  endtask

  // Op changes every cycle; each result must reflect the op captured with its operands.
  task automatic test_back_to_back();
    issue(16'h3A51, 16'h2C72, 2'b00);
    issue(16'h8000, 16'h1000, 2'b01);
    tests_run++; if (bus.out_data !== 16'h5873) begin tests_failed++; $display("FAIL b2b first data: got %h need 5873", bus.out_data); end
    issue(16'h7777, 16'h1111, 2'b10);
    tests_run++; if (bus.out_data !== 16'h8000 || bus.out_ovf !== 4'h8) begin tests_failed++; $display("FAIL b2b second: got %h/%h need 8000/8", bus.out_data, bus.out_ovf); end
    bus.op = 2'b00;
    tick();
    tests_run++; if (bus.out_data !== 16'h8888 || bus.out_valid !== 1'b1) begin tests_failed++; $display("FAIL b2b third: got %h valid %b need 8888 valid 1", bus.out_data, bus.out_valid); end
    tick();
  endtask

  task automatic test_backpressure();
    logic [15:0] ops [4];
    logic [15:0] got [4];
    int sent;
    int rcvd;
    logic acc;
    ops[0] = 16'h1111; ops[1] = 16'h2222; ops[2] = 16'h3333; ops[3] = 16'h4444;
    sent = 0; rcvd = 0;
    bus.out_ready = 1'b0;
    bus.b = 16'h0000; bus.op = 2'b00;
    for (int c = 0; c < 4; c++) begin
      bus.in_valid = 1'b1;
      bus.a = ops[sent];
      #0;
      acc = bus.in_ready;
      tick();
      if (acc) sent++;
      if (c >= 1) begin
        tests_run++; if (bus.out_data !== 16'h1111) begin tests_failed++; $display("FAIL bp hold cycle%0d: got %h need 1111", c, bus.out_data); end
      end
    end
    tests_run++; if (sent !== 2) begin tests_failed++; $display("FAIL bp accepts: got %0d need 2", sent); end
    tests_run++; if (bus.in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp in_ready: got %b need 0", bus.in_ready); end
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20 && rcvd < 4; c++) begin
      bus.in_valid = (sent < 4);
      if (sent < 4) bus.a = ops[sent];
      #0;
      acc = bus.in_ready & bus.in_valid;
      if (bus.out_valid) begin
        got[rcvd] = bus.out_data;
        rcvd++;
      end
      tick();
      if (acc) sent++;
    end
    bus.in_valid = 1'b0;
    tests_run++; if (rcvd !== 4) begin tests_failed++; $display("FAIL bp received: got %0d need 4", rcvd); end
    for (int i = 0; i < 4; i++) begin
      if (i < rcvd) begin
        tests_run++; if (got[i] !== ops[i]) begin tests_failed++; $display("FAIL bp order[%0d]: got %h need %h", i, got[i], ops[i]); end
      end
    end
    tick();
  endtask

  task automatic test_sticky();
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    tests_run++; if (sticky_ovf !== 4'h0) begin tests_failed++; $display("FAIL sticky clear: got %h need 0", sticky_ovf); end
    issue(16'h7000, 16'h1000, 2'b00);
    issue(16'h0007, 16'h0001, 2'b00);
    tests_run++; if (sticky_ovf !== 4'h8) begin tests_failed++; $display("FAIL sticky first: got %h need 8", sticky_ovf); end
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    tests_run++; if (sticky_ovf !== 4'h1) begin tests_failed++; $display("FAIL sticky clr_with_set: got %h need 1", sticky_ovf); end
    tests_run++; if (bus.out_data !== 16'h0007 || bus.out_ovf !== 4'h1) begin tests_failed++; $display("FAIL sticky second op: got %h/%h need 0007/1", bus.out_data, bus.out_ovf); end
    issue(16'h1111, 16'h1111, 2'b00);
    tick();
    tests_run++; if (sticky_ovf !== 4'h1) begin tests_failed++; $display("FAIL sticky hold: got %h need 1", sticky_ovf); end
    tests_run++; if (bus.out_data !== 16'h2222 || bus.out_ovf !== 4'h0) begin tests_failed++; $display("FAIL sticky clean op: got %h/%h need 2222/0", bus.out_data, bus.out_ovf); end
    tick();
  endtask

  task automatic test_reset_mid_op();
    issue(16'h7777, 16'h1111, 2'b00);
    issue(16'h1234, 16'h1111, 2'b00);
    tests_run++; if (sticky_ovf !== 4'hF) begin tests_failed++; $display("FAIL midrst pre sticky: got %h need F", sticky_ovf); end
    rst = 1'b1;
    tick();
    tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst out_valid: got %b need 0", bus.out_valid); end
    tests_run++; if (bus.out_data !== 16'h0000) begin tests_failed++; $display("FAIL midrst out_data: got %h need 0000", bus.out_data); end
    tests_run++; if (sticky_ovf !== 4'h0) begin tests_failed++; $display("FAIL midrst sticky: got %h need 0", sticky_ovf); end
    rst = 1'b0;
    tick(); tick();
    tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst stale result: got valid %b need 0", bus.out_valid); end
    issue(16'h2101, 16'h1203, 2'b00);
    tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst next early: got %b need 0", bus.out_valid); end
    tick();
    tests_run++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h3304) begin tests_failed++; $display("FAIL midrst next op: got valid %b data %h need 1/3304", bus.out_valid, bus.out_data); end
    tick();
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_sat_add();
    test_mixed_lanes();
    test_sub_wrap();
    test_back_to_back();
    test_backpressure();
    test_sticky();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
